fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle RV32I datapath.
- Generates sequential PCs and issues them to instruction memory over a valid/ready request channel, then accepts in-order responses.
- Buffers fetched words with their PCs in a small prefetch FIFO and presents them to decode/datapath through a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes the FIFO and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries; power of two, minimum 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  32  fetch address, word aligned
imem_req_ready  input  1  memory accepts request this cycle
imem_rsp_valid  input  1  response word valid; responses are in request order
imem_rsp_data  input  32  fetched instruction word
redirect_valid  input  1  PC redirect this cycle
redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0
instr_valid  output  1  instruction available to datapath
instr_code  output  32  instruction word (datapath instruction_code)
instr_pc  output  32  PC of instr_code
instr_ready  input  1  datapath consumes instruction this cycle

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; all state clears immediately on assertion.
- Reset values:
  - fetch_pc = RESET_PC, rsp_pc = RESET_PC.
  - outstanding = 0, FIFO empty, state = RUN.
  - imem_req_valid = 0, instr_valid = 0, instr_code = 0, instr_pc = 0.
- Request handshake: occurs when imem_req_valid and imem_req_ready are both high.
  - imem_req_addr = fetch_pc.
  - fetch_pc increments by 4 on each request handshake and wraps from 32'hFFFF_FFFC to 0.
  - imem_req_valid is high when state==RUN, rst low, redirect_valid low, and (outstanding + fifo_count) < FIFO_DEPTH. This credit rule guarantees every response has a FIFO slot; there is no response backpressure.
- Outstanding counter: width clog2(FIFO_DEPTH)+1.
  - +1 on request handshake, -1 on imem_rsp_valid; unchanged when both occur in the same cycle.
  - imem_rsp_valid while outstanding==0 is ignored (protocol error; no state change).
- Response, RUN state:
  - Write {imem_rsp_data, rsp_pc} into the FIFO; rsp_pc += 4, with the same wrap rule as fetch_pc.
  - Latency: response in cycle n gives instr_valid in cycle n+1 (registered FIFO, no bypass).
  - Minimum latency from reset release to the first instr_valid is 2 cycles plus memory latency.
- Output handshake: occurs when instr_valid and instr_ready are both high; pops one entry.
  - instr_code and instr_pc show the FIFO head.
  - instr_valid = FIFO not empty.
  - Outputs hold stable while instr_valid is high and instr_ready is low.
  - Simultaneous push and pop on a full or empty FIFO is legal; the count is unchanged (full) or +1 net zero-skip (empty → entry visible next cycle).
- Redirect (redirect_valid=1), which has priority over everything else:
  - An output handshake in the same cycle still counts as consumed.
  - A response arriving in the same cycle is discarded.
  - No request is issued in the same cycle.
  - On the next edge: FIFO flushed, and fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - Next state is DRAIN if the outstanding count after this cycle is non-zero, else RUN.
- State machine:
  - RUN: normal operation.
  - DRAIN: no requests issued; every response decrements outstanding and is dropped (no FIFO write, rsp_pc unchanged).
  - DRAIN → RUN on the edge where outstanding reaches 0. The first redirect-target request is issued the cycle after entering RUN.
  - A second redirect during DRAIN updates fetch_pc/rsp_pc and stays in DRAIN (or goes to RUN if outstanding reaches 0).
- Reset mid-operation: in-flight responses after reset release are the memory's responsibility; the memory must also be reset.

Test Plan:
- Reset, zero-wait memory (ready=1, response 1 cycle after request, data=addr^32'hA5A5_0000), instr_ready=1:
  - requests at 0x0, 0x4, 0x8 on consecutive cycles;
  - instr_pc sequence 0x0, 0x4, 0x8 with matching instr_code, one per cycle in steady state.
- Backpressure: instr_ready=0 for 10 cycles, FIFO_DEPTH=4:
  - exactly 4 requests issued, then imem_req_valid=0;
  - instr_code/instr_pc stable at PC 0x0;
  - on release, PCs 0x0 through 0x1C drain with no gaps or duplicates.
- Redirect with 2 outstanding (memory latency 3), redirect_pc=0x103:
  - both stale responses dropped;
  - no request while DRAIN;
  - next request addr 0x100; first instr_pc 0x100.
- Simultaneous events: redirect in the same cycle as an output handshake and a response:
  - head counted consumed; response discarded; FIFO empty the next cycle;
  - second redirect to 0x200 during DRAIN → first fetch 0x200.
- Wrap: RESET_PC=32'hFFFF_FFF8 → request addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; instr_pc follows the same sequence.
- Async reset asserted mid-burst between clock edges → imem_req_valid and instr_valid drop immediately; after release the first request is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited instruction memory
// requests, a prefetch FIFO toward decode, and redirect handling that flushes the FIFO
// and drains stale in-flight responses before fetching from the new target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_code,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  // One extra bit so outstanding + occupancy can never overflow the compare.
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]     code_mem [FIFO_DEPTH];
  logic [31:0]     pc_mem   [FIFO_DEPTH];

  logic [CntW:0]   credit_used;
  logic [31:0]     redirect_tgt;
  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_tgt         = {redirect_pc[31:2], 2'b00};

  // Credit rule: never have more words in flight or buffered than FIFO slots, so a
  // response always has somewhere to land and needs no backpressure.
  assign credit_used    = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && (state_q == StRun) && !redirect_valid &&
                          (credit_used < DepthLim);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are protocol errors and are ignored.
  assign rsp_take = imem_rsp_valid && (outst_q != '0);
  assign push     = rsp_take && (state_q == StRun) && !redirect_valid;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_code  = instr_valid ? code_mem[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : '0;

  // Next-state logic for counters, pointers, PCs and the RUN/DRAIN state.
  always_comb begin
    outst_d    = outst_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    state_d    = state_q;

    case ({req_fire, rsp_take})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      rsp_pc_d = rsp_pc_q + 32'd4;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if ((state_q == StDrain) && (outst_d == '0)) begin
      state_d = StRun;
    end

    // Redirect wins: flush, retarget both PCs, and drain whatever is still in flight.
    if (redirect_valid) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      state_d    = (outst_d != '0) ? StDrain : StRun;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only observable through count_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      code_mem[wr_ptr_q] <= imem_rsp_data;
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with configurable latency,
// an epoch-tagged reference model of the delivered instruction stream, and directed
// phases with literal expectations.
module tb_fetch_unit;

  localparam int          Depth = 4;
  localparam logic [31:0] K     = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] epoch;
    logic [31:0] due;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_code, instr_pc;

  logic        w_req_valid, w_rsp_valid, w_instr_valid;
  logic [31:0] w_req_addr, w_rsp_data, w_instr_code, w_instr_pc;
  logic        w_fire_last;
  logic [31:0] w_last_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(Depth)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_code(instr_code), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(Depth)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(1'b1),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_instr_valid), .instr_code(w_instr_code), .instr_pc(w_instr_pc),
    .instr_ready(1'b1)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cyc     = 32'd0;
  logic [31:0] lat     = 32'd1;
  logic [31:0] epoch   = 32'd0;
  logic [31:0] exp_fetch_pc = 32'd0;
  req_t        pend[$];
  req_t        cur;
  logic [31:0] mq[$];

  logic [31:0] req_addr_log[$];
  logic [31:0] req_cyc_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_cyc_log[$];
  logic [31:0] w_addr_log[$];
  logic [31:0] w_pc_log[$];
  logic [31:0] w_code_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] at_q(input logic [31:0] q[$], input int idx);
    if (idx < 0 || idx >= q.size()) return 32'hxxxx_xxxx;
    return q[idx];
  endfunction

  function automatic int first_req_after(input logic [31:0] c);
    for (int i = 0; i < req_cyc_log.size(); i++) begin
      if (req_cyc_log[i] > c) return i;
    end
    return -1;
  endfunction

  task automatic clear_logs();
    req_addr_log.delete();
    req_cyc_log.delete();
    pop_pc_log.delete();
    pop_cyc_log.delete();
  endtask

  // In-order memories: each cycle present the oldest request whose latency has elapsed.
  task automatic mem_drive();
    if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
      cur       = pend.pop_front();
      rsp_valid = 1'b1;
      rsp_data  = cur.addr ^ K;
    end else begin
      rsp_valid = 1'b0;
    end
    w_rsp_valid = w_fire_last && !rst;
    w_rsp_data  = w_last_addr ^ K;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    mem_drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
  endtask

  // Reference model and per-cycle compare, sampled mid-cycle.
  int   stale;
  int   inflight;
  logic exp_req;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr_code", instr_code, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      pend.delete();
      mq.delete();
      exp_fetch_pc = 32'h0000_0000;
      w_fire_last  = 1'b0;
    end else begin
      // Stale = issued before the latest redirect; the unit must not fetch until they drain.
      stale = 0;
      foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
      if (rsp_valid && cur.epoch != epoch) stale++;
      inflight = pend.size() + (rsp_valid ? 1 : 0);
      exp_req  = !redirect_valid && (stale == 0) && ((inflight + mq.size()) < Depth);

      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) chk("req_addr", imem_req_addr, exp_fetch_pc);
      chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("instr_pc", instr_pc, mq[0]);
        chk("instr_code", instr_code, mq[0] ^ K);
      end

      if (imem_req_valid && imem_req_ready) begin
        req_addr_log.push_back(imem_req_addr);
        req_cyc_log.push_back(cyc);
      end
      if (instr_valid && instr_ready) begin
        pop_pc_log.push_back(instr_pc);
        pop_cyc_log.push_back(cyc);
      end

      if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
      if (rsp_valid && !redirect_valid && cur.epoch == epoch) mq.push_back(cur.pc);
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{addr: imem_req_addr, pc: exp_fetch_pc, epoch: epoch,
                         due: cyc + lat});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        mq.delete();
        epoch        = epoch + 32'd1;
        exp_fetch_pc = {redirect_pc[31:2], 2'b00};
      end

      w_fire_last = w_req_valid;
      w_last_addr = w_req_addr;
      if (w_req_valid && w_addr_log.size() < 3) w_addr_log.push_back(w_req_addr);
      if (w_instr_valid && w_pc_log.size() < 3) begin
        w_pc_log.push_back(w_instr_pc);
        w_code_log.push_back(w_instr_code);
      end
    end
  end

  logic [31:0] a;
  logic [31:0] rc;
  int          idx;

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rsp_valid      = 1'b0;
    rsp_data       = 32'h0;
    w_rsp_valid    = 1'b0;
    w_rsp_data     = 32'h0;
    w_fire_last    = 1'b0;
    w_last_addr    = 32'h0;
    step();
    step();

    // Zero-wait memory, free-running consumer.
    lat = 32'd1;
    rst = 1'b0;
    clear_logs();
    a = cyc;
    repeat (8) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("p1_req_addr%0d", i), at_q(req_addr_log, i), 32'(4 * i));
      chk($sformatf("p1_req_cyc%0d", i), at_q(req_cyc_log, i), a + 32'(i));
      chk($sformatf("p1_pop_pc%0d", i), at_q(pop_pc_log, i), 32'(4 * i));
      chk($sformatf("p1_pop_cyc%0d", i), at_q(pop_cyc_log, i), a + 32'(2 + i));
    end

    // Consumer stalled for 10 cycles: credit limit caps requests at FIFO_DEPTH.
    do_reset();
    instr_ready = 1'b0;
    rst = 1'b0;
    clear_logs();
    a = cyc;
    repeat (10) step();
    chk("p2_req_count", 32'(req_addr_log.size()), 32'd4);
    chk("p2_last_req_cyc", at_q(req_cyc_log, 3), a + 32'd3);
    chk("p2_hold_valid", 32'(instr_valid), 32'd1);
    chk("p2_hold_pc", instr_pc, 32'h0);
    chk("p2_hold_code", instr_code, K);
    instr_ready = 1'b1;
    repeat (16) step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("p2_pop_pc%0d", i), at_q(pop_pc_log, i), 32'(4 * i));
      chk($sformatf("p2_pop_cyc%0d", i), at_q(pop_cyc_log, i), a + 32'(10 + i));
    end

    // Redirect with two requests outstanding at latency 3.
    do_reset();
    lat = 32'd3;
    rst = 1'b0;
    clear_logs();
    a = cyc;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    rc = cyc;
    step();
    redirect_valid = 1'b0;
    repeat (12) step();
    idx = first_req_after(rc);
    chk("p3_reqs_before", 32'(idx), 32'd2);
    chk("p3_target_addr", at_q(req_addr_log, idx), 32'h0000_0100);
    chk("p3_target_cyc", at_q(req_cyc_log, idx), rc + 32'd3);
    chk("p3_first_pc", at_q(pop_pc_log, 0), 32'h0000_0100);
    chk("p3_first_code", (pop_pc_log.size() != 0) ? (pop_pc_log[0] ^ K) : 32'hx,
        32'h0000_0100 ^ K);
    chk("p3_first_pop_cyc", at_q(pop_cyc_log, 0), rc + 32'd7);

    // Redirect colliding with an output handshake and a response, then a second
    // redirect while draining.
    do_reset();
    lat = 32'd2;
    rst = 1'b0;
    clear_logs();
    a = cyc;
    repeat (3) step();
    chk("p4_pre_valid", 32'(instr_valid), 32'd1);
    chk("p4_pre_rsp", 32'(rsp_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0180;
    step();
    chk("p4_flushed", 32'(instr_valid), 32'd0);
    redirect_pc = 32'h0000_0200;
    rc = cyc;
    step();
    redirect_valid = 1'b0;
    repeat (10) step();
    chk("p4_consumed_pc", at_q(pop_pc_log, 0), 32'h0);
    chk("p4_consumed_cyc", at_q(pop_cyc_log, 0), a + 32'd3);
    chk("p4_next_pop_pc", at_q(pop_pc_log, 1), 32'h0000_0200);
    idx = first_req_after(rc);
    chk("p4_target_addr", at_q(req_addr_log, idx), 32'h0000_0200);
    chk("p4_target_cyc", at_q(req_cyc_log, idx), rc + 32'd1);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    lat = 32'd1;
    rst = 1'b0;
    repeat (5) step();
    chk("p6_pre_req_valid", 32'(imem_req_valid), 32'd1);
    chk("p6_pre_instr_valid", 32'(instr_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("p6_async_req_valid", 32'(imem_req_valid), 32'd0);
    chk("p6_async_instr_valid", 32'(instr_valid), 32'd0);
    step();
    step();
    rst = 1'b0;
    clear_logs();
    a = cyc;
    repeat (4) step();
    chk("p6_restart_addr", at_q(req_addr_log, 0), 32'h0);
    chk("p6_restart_cyc", at_q(req_cyc_log, 0), a);

    // Wrap-around instance, captured right after the first reset release.
    chk("w_req_addr0", at_q(w_addr_log, 0), 32'hFFFF_FFF8);
    chk("w_req_addr1", at_q(w_addr_log, 1), 32'hFFFF_FFFC);
    chk("w_req_addr2", at_q(w_addr_log, 2), 32'h0000_0000);
    chk("w_pc0", at_q(w_pc_log, 0), 32'hFFFF_FFF8);
    chk("w_pc1", at_q(w_pc_log, 1), 32'hFFFF_FFFC);
    chk("w_pc2", at_q(w_pc_log, 2), 32'h0000_0000);
    chk("w_code0", at_q(w_code_log, 0), 32'h5A5A_FFF8);
    chk("w_code2", at_q(w_code_log, 2), 32'hA5A5_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
